// File: rtl/accum_stage.sv
// Group accumulator: sums unsigned operands until in_last, then holds the result
// (sum, sticky carry, saturating beat count) until the downstream accepts it.

module fulladder_nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         overflow_o
);

  logic [N:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign overflow_o = carry[N];

endmodule

module accum_stage #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     add_sum;
  logic             add_cout;
  logic [CNT_W-1:0] cnt_inc;

  fulladder_nbit #(.N(N)) u_add (
    .a_i        (acc_q),
    .b_i        (in_data),
    .cin_i      (1'b0),
    .sum_o      (add_sum),
    .overflow_o (add_cout)
  );

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = in_data;
          ovf_d   = 1'b0;
          cnt_d   = CNT_ONE;
          state_d = in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = add_sum;
          ovf_d   = ovf_q | add_cout;
          cnt_d   = cnt_inc;
          state_d = in_last ? HOLD : ACC;
        end
      end
      HOLD: begin
        // Result and operand never overlap: the next group starts from IDLE.
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;
  assign out_count    = cnt_q;

endmodule

// File: doc/accum_stage.md
ACCUM_STAGE -- requirements
Module: accum_stage

Interface
REQ-001 Parameter N, default 8: operand and accumulator width in bits, N >= 2.
REQ-002 Parameter CNT_W, default 4: width of the beat counter, CNT_W >= 1.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: reset, synchronous, active-low.
REQ-005 in_valid  input  1: upstream operand present.
REQ-006 in_ready  output  1: block can accept an operand this cycle.
REQ-007 in_data  input  N: unsigned operand.
REQ-008 in_last  input  1: final operand of the current group; sampled only on an accepted beat.
REQ-009 out_valid  output  1: group result available.
REQ-010 out_ready  input  1: downstream accepts the result.
REQ-011 out_sum  output  N: group sum modulo 2^N.
REQ-012 out_overflow  output  1: sticky carry-out seen during the group.
REQ-013 out_count  output  CNT_W: number of beats accepted in the group, saturating.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, ACC, HOLD.
REQ-015 An input beat SHALL be accepted only in a cycle with in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be 1 in IDLE and ACC, and 0 in HOLD.
REQ-017 out_valid SHALL be 1 exactly in HOLD; out_sum, out_overflow and out_count SHALL hold stable throughout HOLD.
REQ-018 Accepted beat in IDLE: acc <= in_data, ovf <= 0, count <= 1; next state HOLD if in_last=1, else ACC.
REQ-019 Accepted beat in ACC: acc <= (acc + in_data) mod 2^N, ovf <= ovf | carry-out of that addition, count <= count+1 (saturating at 2^CNT_W-1); next state HOLD if in_last=1, else ACC.
REQ-020 Addition SHALL be an N-bit ripple add with carry-in 0, instantiating fulladder_nbit; its overflow output SHALL be the carry-out used in REQ-019.
REQ-021 No accepted beat in IDLE/ACC: all state held; in_last is ignored when in_valid=0.
REQ-022 HOLD with out_ready=1: next state IDLE; the next beat is accepted no earlier than the following cycle (no same-cycle result/operand overlap).
REQ-023 HOLD with out_ready=0: remain in HOLD indefinitely; no beat accepted.
REQ-024 Latency: out_valid SHALL rise in the cycle after the in_last beat is accepted.
REQ-025 Throughput: one operand per cycle while in ACC; group turnaround minimum one HOLD cycle.
REQ-026 Outputs out_sum/out_overflow/out_count SHALL reflect internal acc/ovf/count registers in all states (don't-care to downstream outside HOLD).
REQ-027 out_count saturation SHALL NOT affect acc or ovf updates.

Reset
REQ-028 With rst_n=0 at a rising edge: state <= IDLE, acc <= 0, ovf <= 0, count <= 0, regardless of handshake inputs.
REQ-029 After reset: out_valid=0, in_ready=1, out_sum=0, out_overflow=0, out_count=0.
REQ-030 Reset during ACC or HOLD SHALL discard the partial/pending group; no out_valid pulse follows.

Verification (N=8, CNT_W=4)
REQ-031 Beats 10, 20, 30(last), out_ready=1 -> out_valid 1 cycle after beat 30, out_sum=60, out_overflow=0, out_count=3, back to IDLE next cycle.
REQ-032 Beats 200, 100(last) -> out_sum=44, out_overflow=1, out_count=2; next group 5(last) -> out_sum=5, out_overflow=0, out_count=1.
REQ-033 Single beat 255 with in_last=1 -> out_sum=255, out_overflow=0, out_count=1; out_ready=0 for 5 cycles -> out_valid and data stable, in_ready=0, in_valid=1 beats not accepted.
REQ-034 17 beats of 1, last on 17th -> out_sum=17, out_count=15 (saturated), out_overflow=0.
REQ-035 Random in_valid gaps on beats 7, 8, 9(last) -> out_sum=24, out_count=3; gap cycles change no state.
REQ-036 Beats 50, 60, then rst_n=0 one cycle, then 3(last) -> out_valid never asserted before reset, result out_sum=3, out_count=1, out_overflow=0.
